// File: rtl/mips_cpu_writeback.sv
// Writeback stage of the MIPS CPU.
// Accepts completed results from execute/memory, formats load data (byte/half
// extension and LWL/LWR merges), owns HI/LO, and is the only driver of the
// register file write port. Loads stall upstream until the Avalon-style bus
// drops waitrequest.
module mips_cpu_writeback (
    input  logic        clk,
    input  logic        reset,            // active-low, asynchronous assert
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_kind,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_result,
    input  logic [31:0] wb_result_hi,
    input  logic [2:0]  wb_load_op,
    input  logic [1:0]  wb_byte_addr,
    input  logic [31:0] wb_old_rt,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic [4:0]  a3,
    output logic [31:0] writedata,
    output logic        write_en,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Result kinds presented by the execute/memory stage
    localparam logic [2:0] KindAlu  = 3'd0;
    localparam logic [2:0] KindLoad = 3'd1;
    localparam logic [2:0] KindHilo = 3'd2;
    localparam logic [2:0] KindMfhi = 3'd3;
    localparam logic [2:0] KindMflo = 3'd4;

    // Load operations
    localparam logic [2:0] OpLb  = 3'd0;
    localparam logic [2:0] OpLbu = 3'd1;
    localparam logic [2:0] OpLh  = 3'd2;
    localparam logic [2:0] OpLhu = 3'd3;
    localparam logic [2:0] OpLw  = 3'd4;
    localparam logic [2:0] OpLwl = 3'd5;
    localparam logic [2:0] OpLwr = 3'd6;

    typedef enum logic [0:0] {
        StIdle,
        StWaitMem
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] writedata_q, writedata_d;
    logic        write_en_q, write_en_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Load context captured at the transfer edge, used when data returns
    logic [4:0]  ld_dest_q, ld_dest_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic [1:0]  ld_addr_q, ld_addr_d;
    logic [31:0] ld_old_q, ld_old_d;

    logic        xfer;
    logic [31:0] load_value;

    // Little-endian load formatting; o selects the byte lane
    function automatic logic [31:0] format_load(
        input logic [2:0]  op,
        input logic [1:0]  o,
        input logic [31:0] mem,
        input logic [31:0] old
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  sh_l;
        logic [4:0]  sh_r;
        logic [31:0] res;
        b    = mem[{o, 3'b000} +: 8];
        h    = mem[{o[1], 4'b0000} +: 16];
        sh_l = {~o, 3'b000};   // 8*(3-o)
        sh_r = {o, 3'b000};    // 8*o
        unique case (op)
            OpLb:    res = {{24{b[7]}}, b};
            OpLbu:   res = {24'b0, b};
            OpLh:    res = {{16{h[15]}}, h};
            OpLhu:   res = {16'b0, h};
            OpLw:    res = mem;
            OpLwl:   res = (mem << sh_l) | (old & ~(32'hFFFF_FFFF << sh_l));
            OpLwr:   res = (mem >> sh_r) | (old & ~(32'hFFFF_FFFF >> sh_r));
            default: res = mem;
        endcase
        return res;
    endfunction

    assign wb_ready   = (state_q == StIdle);
    assign xfer       = wb_valid & wb_ready;
    assign load_value = format_load(ld_op_q, ld_addr_q, mem_readdata, ld_old_q);

    assign a3        = a3_q;
    assign writedata = writedata_q;
    assign write_en  = write_en_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Next-state: handshake, register-file write port, HI/LO and load context
    always_comb begin
        state_d     = state_q;
        a3_d        = a3_q;
        writedata_d = writedata_q;
        write_en_d  = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        ld_dest_d   = ld_dest_q;
        ld_op_d     = ld_op_q;
        ld_addr_d   = ld_addr_q;
        ld_old_d    = ld_old_q;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    case (wb_kind)
                        KindAlu: begin
                            a3_d        = wb_dest;
                            writedata_d = wb_result;
                            write_en_d  = (wb_dest != 5'd0);
                        end
                        KindMfhi: begin
                            a3_d        = wb_dest;
                            writedata_d = hi_q;
                            write_en_d  = (wb_dest != 5'd0);
                        end
                        KindMflo: begin
                            a3_d        = wb_dest;
                            writedata_d = lo_q;
                            write_en_d  = (wb_dest != 5'd0);
                        end
                        KindHilo: begin
                            hi_d = wb_result_hi;
                            lo_d = wb_result;
                        end
                        KindLoad: begin
                            ld_dest_d = wb_dest;
                            ld_op_d   = wb_load_op;
                            ld_addr_d = wb_byte_addr;
                            ld_old_d  = wb_old_rt;
                            state_d   = StWaitMem;
                        end
                        default: begin
                            // Reserved kinds are dropped
                        end
                    endcase
                end
            end
            StWaitMem: begin
                if (!mem_waitrequest) begin
                    a3_d        = ld_dest_q;
                    writedata_d = load_value;
                    write_en_d  = (ld_dest_q != 5'd0);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any pending load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            a3_q        <= 5'd0;
            writedata_q <= 32'd0;
            write_en_q  <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            ld_dest_q   <= 5'd0;
            ld_op_q     <= 3'd0;
            ld_addr_q   <= 2'd0;
            ld_old_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            a3_q        <= a3_d;
            writedata_q <= writedata_d;
            write_en_q  <= write_en_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ld_dest_q   <= ld_dest_d;
            ld_op_q     <= ld_op_d;
            ld_addr_q   <= ld_addr_d;
            ld_old_q    <= ld_old_d;
        end
    end

endmodule

// File: doc/mips_cpu_writeback.md
# mips_cpu_writeback

Writeback unit for the MIPS CPU. It accepts completed results from the execute/memory stage, finishes load-data formatting (sign/zero extension and LWL/LWR merging), and owns the HI/LO registers. It is the sole driver of the register file's write port (`a3`, `writedata`, `write_en`). It stalls upstream with a valid/ready handshake while a load waits on the Avalon-style memory bus.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `wb_valid`  in  1  upstream has a result
- `wb_ready`  out  1  unit can accept; a transfer happens when `wb_valid & wb_ready` on a rising edge
- `wb_kind`  in  3  0 ALU, 1 LOAD, 2 HILO, 3 MFHI, 4 MFLO; 5-7 are ignored (no effect)
- `wb_dest`  in  5  destination register
- `wb_result`  in  32  ALU/link result; LO value for HILO
- `wb_result_hi`  in  32  HI value for HILO
- `wb_load_op`  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR
- `wb_byte_addr`  in  2  load address bits [1:0]
- `wb_old_rt`  in  32  current rt value, used for the LWL/LWR merge
- `mem_readdata`  in  32  memory read data
- `mem_waitrequest`  in  1  memory stall; data is valid in a WAIT_MEM cycle when low
- `a3`  out  5  register file write address
- `writedata`  out  32  register file write data
- `write_en`  out  1  register file write strobe, one cycle per write
- `hi`, `lo`  out  32 each  HI/LO registers

## Operation
- Two states: IDLE and WAIT_MEM. `wb_ready` = (state == IDLE).
- IDLE, transfer of ALU: next cycle `a3`=`wb_dest`, `writedata`=`wb_result`, `write_en`=1.
- IDLE, transfer of MFHI/MFLO: same as ALU, with data = current `hi`/`lo` sampled at the transfer edge.
- IDLE, transfer of HILO: `hi`<=`wb_result_hi` and `lo`<=`wb_result` on that edge. No register write.
- IDLE, transfer of LOAD: latch dest, op, byte_addr and old_rt, then go to WAIT_MEM.
- WAIT_MEM with `mem_waitrequest`=1: hold the state.
- WAIT_MEM with `mem_waitrequest`=0: format `mem_readdata`, register it to the write port (`write_en`=1 the next cycle) and return to IDLE.
- Load formatting (little-endian; o = byte_addr):
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: halfword at bits [16*o[1]+15 : 16*o[1]]; o[0] is ignored.
  - LW: the full word.
  - LWL: (mem << 8*(3-o)) | (old_rt & ((1<<8*(3-o))-1)).
  - LWR: (mem >> 8*o) | (old_rt & ~(32'hFFFFFFFF >> 8*o)).
- Destination 0: `write_en` is forced to 0. `a3`/`writedata` still update.
- Cycles with no write: `write_en`=0; `a3`/`writedata` hold their last values.
- `hi`/`lo` change only on a HILO transfer.

## Timing
- Reset (async assert, sync release) sets: state=IDLE, `write_en`=0, `a3`=0, `writedata`=0, `hi`=0, `lo`=0. `wb_ready`=1 after reset.
- Reset during WAIT_MEM abandons the pending load; no write occurs.
- ALU/MFHI/MFLO latency is 1 cycle. Back-to-back transfers are allowed every cycle.
- A HILO transfer followed by MFHI in the next cycle returns the new HI value.
- Load latency: the write strobe rises the cycle after the first WAIT_MEM cycle with `mem_waitrequest`=0. Minimum is 2 cycles from transfer.
- `wb_ready` returns to 1 in the same cycle as that write strobe, so the next transfer can overlap it.
- `mem_readdata` is ignored outside WAIT_MEM and while waitrequest=1.
- `wb_valid` with `wb_ready`=0: inputs are ignored; upstream holds them.

## Test plan
- ALU to $5, `wb_result`=0xDEADBEEF -> next cycle `write_en`=1, `a3`=5, `writedata`=0xDEADBEEF. The cycle after, `write_en`=0.
- ALU to $0, value 0x12345678 -> `write_en` stays 0 throughout.
- LB, o=2, waitrequest high for 2 cycles then low with `mem_readdata`=0x1280FF34:
  - `wb_ready` is low for 3 cycles, then the write to `wb_dest` is 0xFFFFFF80.
  - Repeat as LBU -> 0x00000080.
  - Repeat as LH -> 0x00001280.
- LWL and LWR, o=1, mem=0xAABBCCDD, old_rt=0x11223344, zero wait:
  - LWL -> 0xCCDD3344.
  - LWR -> 0x11AABBCC.
- HILO with hi=0x00000001, lo=0xFFFFFFFE, then MFHI to $2 and MFLO to $3 on consecutive cycles -> writes 0x00000001 then 0xFFFFFFFE, with no write for the HILO itself.
- LOAD accepted, then `reset`=0 while in WAIT_MEM -> all outputs are 0 immediately and `wb_ready`=1 after release. No write occurs when waitrequest later falls.
